// File: rtl/z80_bus_ctrl_if.sv
// Bus bundle between the Z80 core (master) and its bus-timing companion (slave).
// Signal names follow the core's pin names.
interface z80_bus_ctrl_if;
  logic        CPU_RUN;
  logic        CEN_P;
  logic        CEN_N;
  logic [15:0] A;
  logic        MREQ_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        WR_n;
  logic        RFSH_n;
  logic        M1_n;
  logic        EXT_WAIT_n;
  logic        WAIT_n;
  logic        nMREQ;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        IO_RD;
  logic        IO_WR;
  logic        NMI_EN;
  logic        NMI_SET;
  logic        NMI_n;

  modport master (
    output CPU_RUN, A, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, M1_n, EXT_WAIT_n, NMI_EN, NMI_SET,
    input  CEN_P, CEN_N, WAIT_n, nMREQ, MEM_RD, MEM_WR, IO_RD, IO_WR, NMI_n
  );

  modport slave (
    input  CPU_RUN, A, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, M1_n, EXT_WAIT_n, NMI_EN, NMI_SET,
    output CEN_P, CEN_N, WAIT_n, nMREQ, MEM_RD, MEM_WR, IO_RD, IO_WR, NMI_n
  );
endinterface

// File: rtl/z80_bus_ctrl.sv
// Z80 bus-timing companion: clock enables, programmable wait states, access strobes
// and the NMI request latch for the sound CPU.
module z80_bus_ctrl #(
  parameter int unsigned CLK_DIV  = 6,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [15:0] NMI_VEC  = 16'h0066
) (
  input  logic          CLK,
  input  logic          RESET,
  z80_bus_ctrl_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_q, io_q;
  logic            wr_n_q, wr_seen_q, wr_seen_d;
  logic            mem_rd_q, mem_wr_q, io_rd_q, io_wr_q;
  logic            mem_rd_d, mem_wr_d, io_rd_d, io_wr_d;
  logic            nmi_set_q, nmi_pend_q, nmi_pend_d;

  logic run, cen_p, cen_n;
  logic mem_acc, io_acc, any_acc, start_mem, start_io, wr_late, nmi_ack, nmi_rise;

  // Divider; enables are gated by reset so they read 0 while RESET is held.
  assign run   = bus_io.CPU_RUN;
  assign cen_p = run & ~RESET & (cnt_q == '0);
  assign cen_n = run & ~RESET & (cnt_q == CntHalf);

  always_comb begin
    cnt_d = cnt_q;
    if (!run)                cnt_d = '0;
    else if (cnt_q == CntMax) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  assign mem_acc   = ~bus_io.MREQ_n & bus_io.RFSH_n;
  assign io_acc    = ~bus_io.IORQ_n;
  assign any_acc   = mem_acc | io_acc;
  assign start_mem = mem_acc & ~mem_q;
  assign start_io  = io_acc & ~io_q;

  // A WR_n falling edge inside an already-running access that has not yet pulsed.
  assign wr_late   = ~bus_io.WR_n & wr_n_q & ~wr_seen_q;
  assign wr_seen_d = any_acc & (wr_seen_q | ~bus_io.WR_n);

  always_comb begin
    mem_rd_d = start_mem & ~bus_io.RD_n;
    io_rd_d  = start_io & ~bus_io.RD_n;
    mem_wr_d = (start_mem & ~bus_io.WR_n) | (wr_late & mem_acc & mem_q);
    io_wr_d  = (start_io & ~bus_io.WR_n) | (wr_late & io_acc & io_q);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (start_io) begin
          wcnt_d  = 4'(IO_WAIT);
          state_d = (IO_WAIT != 0) ? StWait : StHold;
        end else if (start_mem) begin
          wcnt_d  = 4'(MEM_WAIT);
          state_d = (MEM_WAIT != 0) ? StWait : StHold;
        end
      end
      StWait: begin
        if (!any_acc) begin
          state_d = StIdle;
        end else if (cen_n) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = StHold;
        end
      end
      StHold: begin
        if (!any_acc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign nmi_ack    = ~bus_io.M1_n & ~bus_io.MREQ_n & (bus_io.A == NMI_VEC);
  assign nmi_rise   = bus_io.NMI_SET & ~nmi_set_q;
  // Acknowledge or disable wins over a coincident trigger edge.
  assign nmi_pend_d = (nmi_ack | ~bus_io.NMI_EN) ? 1'b0 : (nmi_rise | nmi_pend_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      state_q    <= StIdle;
      wcnt_q     <= '0;
      mem_q      <= 1'b0;
      io_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      wr_seen_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      nmi_set_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      mem_q      <= mem_acc;
      io_q       <= io_acc;
      wr_n_q     <= bus_io.WR_n;
      wr_seen_q  <= wr_seen_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      nmi_set_q  <= bus_io.NMI_SET;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign bus_io.CEN_P  = cen_p;
  assign bus_io.CEN_N  = cen_n;
  assign bus_io.WAIT_n = (state_q != StWait) & bus_io.EXT_WAIT_n;
  assign bus_io.nMREQ  = bus_io.MREQ_n | ~bus_io.RFSH_n;
  assign bus_io.MEM_RD = mem_rd_q;
  assign bus_io.MEM_WR = mem_wr_q;
  assign bus_io.IO_RD  = io_rd_q;
  assign bus_io.IO_WR  = io_wr_q;
  assign bus_io.NMI_n  = ~nmi_pend_q;

endmodule
